// File: rtl/cpu_pkg.sv
// Shared definitions for the 16-bit pipelined core: widths, instruction field
// positions, opcodes and opcode classification helpers.
package cpu_pkg;

    localparam int DATA_W   = 16;
    localparam int REG_AW   = 3;
    localparam int MEM_AW   = 8;
    localparam int NUM_REGS = 1 << REG_AW;
    localparam int INSTR_W  = 32;
    localparam int OP_W     = 5;

    localparam int OP_LSB  = 27;
    localparam int RD_LSB  = 24;
    localparam int RS1_LSB = 21;
    localparam int RS2_LSB = 18;
    localparam int IMM_LSB = 0;

    typedef logic [OP_W-1:0] opcode_t;

    localparam opcode_t OP_NOP  = 5'h00;
    localparam opcode_t OP_ADD  = 5'h01;
    localparam opcode_t OP_SUB  = 5'h02;
    localparam opcode_t OP_AND  = 5'h03;
    localparam opcode_t OP_OR   = 5'h04;
    localparam opcode_t OP_XOR  = 5'h05;
    localparam opcode_t OP_NOT  = 5'h06;
    localparam opcode_t OP_SHL  = 5'h07;
    localparam opcode_t OP_SHR  = 5'h08;
    localparam opcode_t OP_ADDI = 5'h09;
    localparam opcode_t OP_LDI  = 5'h0A;
    localparam opcode_t OP_MOV  = 5'h0B;
    localparam opcode_t OP_LD   = 5'h0C;
    localparam opcode_t OP_ST   = 5'h0D;
    localparam opcode_t OP_OUT  = 5'h0E;

    // Opcodes ADD..MOV plus LD produce a register result.
    function automatic logic op_writes_rd(input opcode_t op);
        return ((op >= OP_ADD) && (op <= OP_MOV)) || (op == OP_LD);
    endfunction

    function automatic logic op_sets_flags(input opcode_t op);
        return (op >= OP_ADD) && (op <= OP_ADDI);
    endfunction

endpackage

// File: rtl/sram.sv
// Synchronous single-port data SRAM: registered read every edge, write when we,
// read-during-write returns the old word. Contents are never reset.
module sram
    import cpu_pkg::*;
(
    input  logic              clk,
    input  logic [DATA_W-1:0] addr,
    input  logic [DATA_W-1:0] data_in,
    input  logic              we,
    output logic [DATA_W-1:0] data_out
);

    logic [DATA_W-1:0] mem [1 << MEM_AW];
    logic              unused_addr_hi;

    // Upper address bits fall outside the 256-word array.
    assign unused_addr_hi = ^addr[DATA_W-1:MEM_AW];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr[MEM_AW-1:0]] <= data_in;
        end
        data_out <= mem[addr[MEM_AW-1:0]];
    end

endmodule

// File: rtl/final_top_cpu.sv
// Three-stage (decode / execute / writeback) 16-bit core with no PC and no
// hazard handling; memory accesses go to an external synchronous SRAM.
module final_top_cpu
    import cpu_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic [INSTR_W-1:0] instruction,
    input  logic [DATA_W-1:0]  data_in,
    output logic [DATA_W-1:0]  data_out,
    output logic [DATA_W-1:0]  addr,
    output logic               we,
    output logic [DATA_W-1:0]  out_reg,
    output logic               zero,
    output logic               carry
);

    opcode_t           raw_op, dec_op;
    logic [REG_AW-1:0] dec_rd, dec_rs1, dec_rs2;
    logic [DATA_W-1:0] dec_imm, rs1_val, rs2_val;
    logic              unused_resv;

    opcode_t           idex_op_reg;
    logic [REG_AW-1:0] idex_rd_reg;
    logic [DATA_W-1:0] idex_a_reg, idex_b_reg, idex_imm_reg;

    opcode_t           exwb_op_reg;
    logic [REG_AW-1:0] exwb_rd_reg;
    logic [DATA_W-1:0] exwb_res_reg;

    logic                             wb_en;
    logic [DATA_W-1:0]                wb_data;
    logic [NUM_REGS-1:0][DATA_W-1:0] rf_q;

    logic [DATA_W:0]   ex_sum;
    logic [DATA_W-1:0] ex_res, ex_mem_addr;
    logic              ex_carry, ex_is_mem;

    assign raw_op      = instruction[OP_LSB +: OP_W];
    assign dec_op      = (raw_op > OP_OUT) ? OP_NOP : raw_op;
    assign dec_rd      = instruction[RD_LSB +: REG_AW];
    assign dec_rs1     = instruction[RS1_LSB +: REG_AW];
    assign dec_rs2     = instruction[RS2_LSB +: REG_AW];
    assign dec_imm     = instruction[IMM_LSB +: DATA_W];
    assign unused_resv = ^instruction[RS2_LSB-1:DATA_W];

    assign wb_en   = op_writes_rd(exwb_op_reg);
    assign wb_data = (exwb_op_reg == OP_LD) ? data_in : exwb_res_reg;

    generate
        for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_rf
            logic [DATA_W-1:0] gpr_reg;
            always_ff @(posedge clk) begin
                if (!rst) begin
                    gpr_reg <= '0;
                end else if (wb_en && (exwb_rd_reg == REG_AW'(gi))) begin
                    gpr_reg <= wb_data;
                end
            end
            assign rf_q[gi] = gpr_reg;
        end
    endgenerate

    // Write-through: a decode reading the register being written this edge sees the new value.
    assign rs1_val = (wb_en && (exwb_rd_reg == dec_rs1)) ? wb_data : rf_q[dec_rs1];
    assign rs2_val = (wb_en && (exwb_rd_reg == dec_rs2)) ? wb_data : rf_q[dec_rs2];

    always_ff @(posedge clk) begin
        if (!rst) begin
            idex_op_reg  <= OP_NOP;
            idex_rd_reg  <= '0;
            idex_a_reg   <= '0;
            idex_b_reg   <= '0;
            idex_imm_reg <= '0;
        end else begin
            idex_op_reg  <= dec_op;
            idex_rd_reg  <= dec_rd;
            idex_a_reg   <= rs1_val;
            idex_b_reg   <= rs2_val;
            idex_imm_reg <= dec_imm;
        end
    end

    assign ex_mem_addr = idex_a_reg + idex_imm_reg;

    always_comb begin
        ex_sum   = '0;
        ex_res   = '0;
        ex_carry = 1'b0;
        case (idex_op_reg)
            OP_ADD: begin
                ex_sum   = {1'b0, idex_a_reg} + {1'b0, idex_b_reg};
                ex_res   = ex_sum[DATA_W-1:0];
                ex_carry = ex_sum[DATA_W];
            end
            OP_SUB: begin
                ex_res   = idex_a_reg - idex_b_reg;
                ex_carry = idex_a_reg < idex_b_reg;
            end
            OP_AND: ex_res = idex_a_reg & idex_b_reg;
            OP_OR:  ex_res = idex_a_reg | idex_b_reg;
            OP_XOR: ex_res = idex_a_reg ^ idex_b_reg;
            OP_NOT: ex_res = ~idex_a_reg;
            OP_SHL: begin
                ex_res   = {idex_a_reg[DATA_W-2:0], 1'b0};
                ex_carry = idex_a_reg[DATA_W-1];
            end
            OP_SHR: begin
                ex_res   = {1'b0, idex_a_reg[DATA_W-1:1]};
                ex_carry = idex_a_reg[0];
            end
            OP_ADDI: begin
                ex_sum   = {1'b0, idex_a_reg} + {1'b0, idex_imm_reg};
                ex_res   = ex_sum[DATA_W-1:0];
                ex_carry = ex_sum[DATA_W];
            end
            OP_LDI: ex_res = idex_imm_reg;
            OP_MOV: ex_res = idex_a_reg;
            OP_OUT: ex_res = idex_a_reg;
            default: ex_res = '0;
        endcase
    end

    // Gating with rst keeps a store caught mid-execute by reset from reaching memory.
    assign ex_is_mem = (idex_op_reg == OP_LD) || (idex_op_reg == OP_ST);
    assign we        = rst && (idex_op_reg == OP_ST);
    assign addr      = (rst && ex_is_mem) ? ex_mem_addr : '0;
    assign data_out  = we ? idex_b_reg : '0;

    always_ff @(posedge clk) begin
        if (!rst) begin
            exwb_op_reg  <= OP_NOP;
            exwb_rd_reg  <= '0;
            exwb_res_reg <= '0;
            zero         <= 1'b0;
            carry        <= 1'b0;
        end else begin
            exwb_op_reg  <= idex_op_reg;
            exwb_rd_reg  <= idex_rd_reg;
            exwb_res_reg <= ex_res;
            if (op_sets_flags(idex_op_reg)) begin
                zero  <= (ex_res == '0);
                carry <= ex_carry;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            out_reg <= '0;
        end else if (exwb_op_reg == OP_OUT) begin
            out_reg <= exwb_res_reg;
        end
    end

endmodule

// File: tb/tb_final_top_cpu.sv
// Scoreboard bench: each instruction is held 4 cycles, a spec-level model predicts
// the observable outputs, and a monitor compares them at the end of each group.
module tb_final_top_cpu;
    import cpu_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] instruction = '0;
    logic [15:0] data_in, data_out, addr, out_reg;
    logic        we, zero, carry;

    final_top_cpu dut (
        .clk(clk), .rst(rst), .instruction(instruction), .data_in(data_in),
        .data_out(data_out), .addr(addr), .we(we), .out_reg(out_reg),
        .zero(zero), .carry(carry)
    );

    sram u_sram (
        .clk(clk), .addr(addr), .data_in(data_out), .we(we), .data_out(data_in)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed {
        logic [31:0] due;
        logic [31:0] instr;
        logic [15:0] addr;
        logic [15:0] dout;
        logic [15:0] outr;
        logic        we;
        logic        z;
        logic        c;
        logic        full;
    } exp_t;

    exp_t sb_q[$];
    int   n_vec = 0;
    int   n_mis = 0;

    // Architectural reference state: every instruction takes effect atomically.
    logic [15:0] m_rf  [8];
    logic [15:0] m_mem [256];
    logic [15:0] m_out;
    logic        m_z, m_c;

    function automatic logic [31:0] enc(input logic [4:0] op, input logic [2:0] rd,
                                        input logic [2:0] rs1, input logic [2:0] rs2,
                                        input logic [15:0] imm);
        return {op, rd, rs1, rs2, 2'b00, imm};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 8; i++) m_rf[i] = '0;
        m_out = '0;
        m_z   = 1'b0;
        m_c   = 1'b0;
    endtask

    task automatic model_exec(input logic [31:0] ins, output exp_t e);
        logic [4:0]  op;
        logic [2:0]  rd, s1, s2;
        logic [15:0] a, b, imm, r, ea;
        int          sum;
        logic        cy, fl, wr;
        op = ins[31:27]; rd = ins[26:24]; s1 = ins[23:21]; s2 = ins[20:18]; imm = ins[15:0];
        a = m_rf[s1]; b = m_rf[s2]; ea = a + imm;
        r = '0; cy = 1'b0; fl = 1'b1; wr = 1'b1; sum = 0;
        e = '0;
        case (op)
            5'h01: begin sum = int'(a) + int'(b); r = sum[15:0]; cy = (sum > 65535); end
            5'h02: begin r = a - b; cy = (a < b); end
            5'h03: r = a & b;
            5'h04: r = a | b;
            5'h05: r = a ^ b;
            5'h06: r = ~a;
            5'h07: begin r = 16'(int'(a) * 2); cy = (a >= 16'h8000); end
            5'h08: begin r = a / 2; cy = (a % 2 == 1); end
            5'h09: begin sum = int'(a) + int'(imm); r = sum[15:0]; cy = (sum > 65535); end
            5'h0A: begin r = imm; fl = 1'b0; end
            5'h0B: begin r = a; fl = 1'b0; end
            5'h0C: begin r = m_mem[ea[7:0]]; fl = 1'b0; e.addr = ea; end
            5'h0D: begin
                m_mem[ea[7:0]] = b; fl = 1'b0; wr = 1'b0;
                e.addr = ea; e.dout = b; e.we = 1'b1;
            end
            5'h0E: begin m_out = a; fl = 1'b0; wr = 1'b0; end
            default: begin fl = 1'b0; wr = 1'b0; end
        endcase
        if (wr) m_rf[rd] = r;
        if (fl) begin m_z = (r == 16'h0000); m_c = cy; end
        e.outr = m_out; e.z = m_z; e.c = m_c; e.full = 1'b1; e.instr = ins;
    endtask

    // Called on a falling edge; the instruction is sampled by the next 4 rising edges.
    task automatic issue(input logic [31:0] ins);
        exp_t e;
        model_exec(ins, e);
        instruction = ins;
        e.due = cyc + 4;
        sb_q.push_back(e);
        repeat (4) @(negedge clk);
    endtask

    task automatic push_zero_check();
        exp_t e;
        e = '0;
        e.due  = cyc;
        e.full = 1'b1;
        sb_q.push_back(e);
    endtask

    task automatic rand_instr(output logic [31:0] ins);
        int          k;
        logic [4:0]  op;
        logic [2:0]  rd, s1, s2;
        logic [15:0] imm, tgt;
        k  = $urandom_range(0, 19);
        op = (k <= 14) ? 5'(k) : 5'($urandom_range(15, 31));
        s1 = 3'($urandom_range(0, 7));
        s2 = 3'($urandom_range(0, 7));
        // rd never aliases a source, so repeating the instruction is idempotent.
        do rd = 3'($urandom_range(0, 7)); while (rd == s1 || rd == s2);
        imm = 16'($urandom);
        if (op == OP_LD || op == OP_ST) begin
            tgt = {8'($urandom), 4'h4, 4'($urandom)};
            imm = tgt - m_rf[s1];
        end
        ins = enc(op, rd, s1, s2, imm);
    endtask

    task automatic cmp(input string name, input logic [31:0] ins,
                       input logic [15:0] act, input logic [15:0] exp_v);
        n_vec++;
        if (act !== exp_v) begin
            n_mis++;
            $display("FAIL %s instr=%08h got=%04h expected=%04h", name, ins, act, exp_v);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            #1;
            while (sb_q.size() > 0 && sb_q[0].due <= cyc) begin
                e = sb_q.pop_front();
                cmp("we", e.instr, 16'(we), 16'(e.we));
                if (e.full) begin
                    cmp("addr", e.instr, addr, e.addr);
                    cmp("data_out", e.instr, data_out, e.dout);
                    cmp("out_reg", e.instr, out_reg, e.outr);
                    cmp("zero", e.instr, 16'(zero), 16'(e.z));
                    cmp("carry", e.instr, 16'(carry), 16'(e.c));
                end
                $display("chk cyc=%0d instr=%08h addr=%04h dout=%04h we=%b out=%04h z=%b c=%b",
                         cyc, e.instr, addr, data_out, we, out_reg, zero, carry);
            end
        end
    end

    initial begin : driver
        logic [31:0] ins;
        exp_t        e;
        model_reset();
        for (int i = 0; i < 256; i++) m_mem[i] = '0;

        // Power-up reset held for 4 edges.
        rst = 1'b0;
        instruction = '0;
        repeat (4) @(negedge clk);
        push_zero_check();
        rst = 1'b1;

        // Seed the random load/store window 0x40..0x4F (high address byte varies).
        for (int k = 0; k < 16; k++) begin
            issue(enc(OP_LDI, 3'd1, 3'd0, 3'd0, {8'($urandom), 8'(8'h40 + k)}));
            issue(enc(OP_LDI, 3'd2, 3'd0, 3'd0, 16'($urandom)));
            issue(enc(OP_ST, 3'd0, 3'd1, 3'd2, 16'h0000));
        end

        issue(enc(OP_LDI, 3'd1, 3'd0, 3'd0, 16'hFFFF));
        issue(enc(OP_LDI, 3'd2, 3'd0, 3'd0, 16'h0001));
        issue(enc(OP_ADD, 3'd3, 3'd1, 3'd2, 16'h0000));

        issue(enc(OP_LDI, 3'd1, 3'd0, 3'd0, 16'h0005));
        issue(enc(OP_LDI, 3'd2, 3'd0, 3'd0, 16'h0007));
        issue(enc(OP_SUB, 3'd3, 3'd1, 3'd2, 16'h0000));
        issue(enc(OP_OUT, 3'd0, 3'd3, 3'd0, 16'h0000));

        issue(enc(OP_LDI, 3'd1, 3'd0, 3'd0, 16'h0010));
        issue(enc(OP_LDI, 3'd2, 3'd0, 3'd0, 16'hBEEF));
        issue(enc(OP_ST, 3'd0, 3'd1, 3'd2, 16'h0002));

        issue(enc(OP_LDI, 3'd1, 3'd0, 3'd0, 16'h0010));
        issue(enc(OP_NOP, 3'd0, 3'd0, 3'd0, 16'h0000));
        issue(enc(OP_LD, 3'd4, 3'd1, 3'd0, 16'h0002));
        issue(enc(OP_OUT, 3'd0, 3'd4, 3'd0, 16'h0000));

        repeat (150) begin
            rand_instr(ins);
            issue(ins);
        end

        // Reset arriving while a store sits in EXECUTE.
        issue(enc(OP_LDI, 3'd1, 3'd0, 3'd0, 16'hFFFF));
        issue(enc(OP_LDI, 3'd2, 3'd0, 3'd0, 16'h0001));
        issue(enc(OP_ADD, 3'd3, 3'd1, 3'd2, 16'h0000));
        issue(enc(OP_LDI, 3'd5, 3'd0, 3'd0, 16'h0045));
        issue(enc(OP_LDI, 3'd6, 3'd0, 3'd0, ~m_mem[8'h45]));
        instruction = enc(OP_ST, 3'd0, 3'd5, 3'd6, 16'h0000);
        @(negedge clk);
        rst = 1'b0;
        instruction = '0;
        e = '0;
        e.due   = cyc;
        e.instr = enc(OP_ST, 3'd0, 3'd5, 3'd6, 16'h0000);
        sb_q.push_back(e);
        @(negedge clk);
        push_zero_check();
        model_reset();
        repeat (2) @(negedge clk);
        rst = 1'b1;
        issue(enc(OP_LDI, 3'd1, 3'd0, 3'd0, 16'h0045));
        issue(enc(OP_LD, 3'd4, 3'd1, 3'd0, 16'h0000));
        issue(enc(OP_OUT, 3'd0, 3'd4, 3'd0, 16'h0000));

        for (int t = 0; t < 20 && sb_q.size() > 0; t++) @(negedge clk);
        if (sb_q.size() > 0) begin
            n_vec++;
            n_mis++;
            $display("FAIL drain pending=%0d expected=0", sb_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
